// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between a data-memory initiator and the responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle word-wide data memory slave with byte-enabled stores, fixed wait
// states and an error response for misaligned or out-of-range addresses.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_responder_if.slave bus
);
  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  // 33-bit end address so a window ending at 2^32 does not wrap to zero
  localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + (33'(DEPTH_WORDS) << 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state;
  logic [3:0]  cnt;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic             addr_err;
  logic [IDX_W-1:0] idx;

  // Base is word-aligned, so the low index bits of (addr - base) only depend
  // on the low address bits.
  always_comb begin
    addr_err = (addr_q[1:0] != 2'b00)
            || ({1'b0, addr_q} < {1'b0, ADDR_BASE})
            || ({1'b0, addr_q} >= ADDR_END);
    idx      = addr_q[IDX_W+1:2] - ADDR_BASE[IDX_W+1:2];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            write_q       <= bus.req_write;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            be_q          <= bus.req_be;
            bus.req_ready <= 1'b0;
            if (WAIT_CYCLES != 0) begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_CYCLES);
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_ACCESS;
        end
        S_ACCESS: begin
          state          <= S_RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= addr_err;
          bus.resp_rdata <= (addr_err || write_q) ? '0 : mem[idx];
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array is not reset; a store in ACCESS commits even if reset lands that edge.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && write_q && !addr_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised and directed bench for two responder configurations against a
// transaction-level memory model.
module tb_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  data_mem_responder_if bus0();
  data_mem_responder_if bus1();

  data_mem_responder #(.DEPTH_WORDS(256), .ADDR_BASE(32'h0000_0000), .WAIT_CYCLES(2))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  data_mem_responder #(.DEPTH_WORDS(16), .ADDR_BASE(32'hFFFF_FFC0), .WAIT_CYCLES(0))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  int     wait_of  [2] = '{2, 0};
  longint base_of  [2] = '{64'h0, 64'hFFFF_FFC0};
  longint depth_of [2] = '{256, 16};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic g_ready(input int d);
    return (d == 0) ? bus0.req_ready : bus1.req_ready;
  endfunction
  function automatic logic g_rv(input int d);
    return (d == 0) ? bus0.resp_valid : bus1.resp_valid;
  endfunction
  function automatic logic g_err(input int d);
    return (d == 0) ? bus0.resp_err : bus1.resp_err;
  endfunction
  function automatic logic [31:0] g_rdata(input int d);
    return (d == 0) ? bus0.resp_rdata : bus1.resp_rdata;
  endfunction

  task automatic set_req(input int d, input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    if (d == 0) begin
      bus0.req_valid = v; bus0.req_write = w; bus0.req_addr = a;
      bus0.req_wdata = wd; bus0.req_be = be;
    end else begin
      bus1.req_valid = v; bus1.req_write = w; bus1.req_addr = a;
      bus1.req_wdata = wd; bus1.req_be = be;
    end
  endtask

  task automatic set_rr(input int d, input logic x);
    if (d == 0) bus0.resp_ready = x;
    else        bus1.resp_ready = x;
  endtask

  // ---------------- behavioural model ----------------
  logic        m_live = 1'b0;
  logic        m_ready [2], m_rv [2], m_err [2], m_known [2], m_inflight [2];
  logic [31:0] m_rdata [2];
  int          m_cnt [2];
  logic        m_w [2];
  logic [31:0] m_a [2], m_wd [2];
  logic [3:0]  m_be [2];
  logic [7:0]  mbyte [longint];

  task automatic model_access(input int d);
    longint a = longint'(m_a[d]);
    logic bad = (a % 4 != 0) || (a < base_of[d]) || (a >= base_of[d] + 4 * depth_of[d]);
    longint key = (longint'(d) << 40) + (a - base_of[d]);
    m_known[d] = 1'b1;
    m_rdata[d] = '0;
    m_err[d]   = bad;
    if (!bad) begin
      for (int i = 0; i < 4; i++) begin
        if (m_w[d]) begin
          if (m_be[d][i]) mbyte[key + i] = m_wd[d][8*i +: 8];
        end else begin
          if (mbyte.exists(key + i)) m_rdata[d][8*i +: 8] = mbyte[key + i];
          else m_known[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic model_step(input int d, input logic v, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be, input logic rr);
    if (!reset) begin
      if (m_inflight[d] && m_cnt[d] == 1) model_access(d);
      m_ready[d] = 1'b0; m_rv[d] = 1'b0; m_err[d] = 1'b0; m_rdata[d] = '0;
      m_inflight[d] = 1'b0; m_cnt[d] = 0; m_known[d] = 1'b1;
    end else if (m_rv[d]) begin
      if (rr) begin m_rv[d] = 1'b0; m_ready[d] = 1'b1; end
    end else if (m_inflight[d]) begin
      m_cnt[d]--;
      if (m_cnt[d] == 0) begin
        model_access(d);
        m_inflight[d] = 1'b0;
        m_rv[d] = 1'b1;
      end
    end else if (!m_ready[d]) begin
      m_ready[d] = 1'b1;
    end else if (v) begin
      m_ready[d] = 1'b0;
      m_w[d] = w; m_a[d] = a; m_wd[d] = wd; m_be[d] = be;
      m_inflight[d] = 1'b1;
      m_cnt[d] = wait_of[d] + 1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, bus0.req_valid, bus0.req_write, bus0.req_addr, bus0.req_wdata, bus0.req_be, bus0.resp_ready);
    model_step(1, bus1.req_valid, bus1.req_write, bus1.req_addr, bus1.req_wdata, bus1.req_be, bus1.resp_ready);
    if (!reset) m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("req_ready[%0d]", d), 32'(g_ready(d)), 32'(m_ready[d]));
        chk($sformatf("resp_valid[%0d]", d), 32'(g_rv(d)), 32'(m_rv[d]));
        if (m_rv[d]) begin
          chk($sformatf("resp_err[%0d]", d), 32'(g_err(d)), 32'(m_err[d]));
          if (m_known[d]) chk($sformatf("resp_rdata[%0d]", d), g_rdata(d), m_rdata[d]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_rv(input int d, output int lat);
    lat = 0;
    while (!g_rv(d) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic transact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, input int hold,
                          output logic [31:0] rd, output logic e);
    int n;
    int lat;
    set_req(d, 1'b1, w, a, wd, be);
    n = 0;
    while (!g_ready(d) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 32'(n < 50), 32'd1);
    @(negedge clk);
    set_req(d, 1'b0, 1'b0, '0, '0, '0);
    wait_rv(d, lat);
    chk($sformatf("latency[%0d]", d), 32'(lat + 1), 32'(wait_of[d] + 2));
    rd = g_rdata(d);
    e  = g_err(d);
    repeat (hold) @(negedge clk);
    set_rr(d, 1'b1);
    @(negedge clk);
    set_rr(d, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat, acc, last;
    logic [31:0] a;
    int          d, k;

    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 1'b0, 1'b0, '0, '0, '0);
      set_rr(i, 1'b0);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(g_ready(i)), 32'd0);
      chk("rst_valid", 32'(g_rv(i)), 32'd0);
      chk("rst_rdata", g_rdata(i), 32'h0);
      chk("rst_err", 32'(g_err(i)), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_release", 32'(g_ready(0)), 32'd1);

    // basic store/load
    transact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, e);
    chk("t1_store_err", 32'(e), 32'd0);
    chk("t1_store_rdata", rd, 32'h0);
    transact(0, 1'b0, 32'h10, 32'h0, 4'h0, 1, rd, e);
    chk("t1_load", rd, 32'hDEADBEEF);
    chk("t1_load_err", 32'(e), 32'd0);

    // byte lanes
    transact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, e);
    transact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, e);
    transact(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, rd, e);
    chk("t2_be0_err", 32'(e), 32'd0);
    transact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd, e);
    chk("t2_merge", rd, 32'h11BB33DD);

    // errors
    transact(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, rd, e);
    transact(0, 1'b1, 32'h3FC, 32'h0BADC0DE, 4'hF, 0, rd, e);
    transact(0, 1'b0, 32'h22, 32'h0, 4'hF, 0, rd, e);
    chk("t3_misalign_err", 32'(e), 32'd1);
    chk("t3_misalign_rdata", rd, 32'h0);
    transact(0, 1'b1, 32'h400, 32'h12345678, 4'hF, 2, rd, e);
    chk("t3_range_err", 32'(e), 32'd1);
    chk("t3_range_rdata", rd, 32'h0);
    transact(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0, rd, e);
    chk("t3_top_word", rd, 32'h0BADC0DE);
    transact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, e);
    chk("t3_word0", rd, 32'hCAFEF00D);

    // response back-pressure with a competing request
    set_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    wait_rv(0, lat);
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(g_rv(0)), 32'd1);
      chk("t4_hold_rdata", g_rdata(0), 32'h11BB33DD);
      chk("t4_hold_err", 32'(g_err(0)), 32'd0);
      chk("t4_hold_ready", 32'(g_ready(0)), 32'd0);
      @(negedge clk);
    end
    set_rr(0, 1'b1);
    @(negedge clk);
    set_rr(0, 1'b0);
    chk("t4_idle_ready", 32'(g_ready(0)), 32'd1);
    chk("t4_idle_valid", 32'(g_rv(0)), 32'd0);
    @(negedge clk);
    chk("t4_pending_taken", 32'(g_ready(0)), 32'd0);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    wait_rv(0, lat);
    chk("t4_pending_rdata", g_rdata(0), 32'hDEADBEEF);
    set_rr(0, 1'b1);
    @(negedge clk);
    set_rr(0, 1'b0);

    // reset during WAIT aborts a store
    transact(0, 1'b1, 32'h30, 32'h0, 4'hF, 0, rd, e);
    set_req(0, 1'b1, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_no_stale_valid", 32'(g_rv(0)), 32'd0);
    chk("t5_ready", 32'(g_ready(0)), 32'd1);
    transact(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, rd, e);
    chk("t5_no_write", rd, 32'h0);

    // zero wait states, window ending at 2^32
    transact(1, 1'b1, 32'hFFFF_FFFC, 32'h55AA55AA, 4'hF, 0, rd, e);
    chk("t6_top_store_err", 32'(e), 32'd0);
    transact(1, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 0, rd, e);
    chk("t6_top_load", rd, 32'h55AA55AA);
    transact(1, 1'b0, 32'hFFFF_FFBC, 32'h0, 4'h0, 0, rd, e);
    chk("t6_below_err", 32'(e), 32'd1);
    transact(1, 1'b1, 32'hFFFF_FFC0, 32'h01020304, 4'hF, 0, rd, e);
    set_rr(1, 1'b1);
    set_req(1, 1'b1, 1'b0, 32'hFFFF_FFC0, 32'h0, 4'h0);
    acc = 0;
    last = -3;
    for (int i = 0; i < 30; i++) begin
      if (g_ready(1)) begin
        chk("t6_interval", 32'(i - last), 32'd3);
        last = i;
        acc++;
      end
      @(negedge clk);
    end
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    set_rr(1, 1'b0);
    chk("t6_throughput", 32'(acc), 32'd10);

    // randomised traffic on both configurations
    for (int n = 0; n < 80; n++) begin
      d = int'($urandom_range(0, 1));
      k = int'($urandom_range(0, 9));
      case (k)
        6:       a = 32'(base_of[d] + 4 * longint'($urandom_range(0, 32'(depth_of[d] - 1))) + longint'($urandom_range(1, 3)));
        7:       a = 32'(base_of[d] + 4 * depth_of[d]);
        8:       a = 32'(base_of[d] - 4);
        9:       a = $urandom;
        default: a = 32'(base_of[d] + 4 * longint'($urandom_range(0, 32'(depth_of[d] - 1))));
      endcase
      transact(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
               int'($urandom_range(0, 2)), rd, e);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
